// File: rtl/count_seq_checker.sv
// count_seq_checker
//
// Checks a free-running counter stream at its receiving end. The first
// valid sample is taken as a reference. The checker then expects the
// stream to step by one per valid sample: down with wrap 0 -> max when
// DIR=0, or up with wrap max -> 0 when DIR=1. LOCK_CNT consecutive
// in-sequence samples, including the reference, declare lock.
//
// While locked, a mismatching sample does three things:
//   - raises err_pulse for one cycle;
//   - increments err_count;
//   - drops back to acquisition, with the bad sample as the new reference.
//
// A matched sample equal to the wrap target increments wrap_count. Both
// statistic counters saturate and never roll over.
//
// Ports:
//   clk        : clock, all logic on the rising edge
//   reset      : asynchronous active-low reset
//   cnt_in     : counter sample under check
//   cnt_valid  : cnt_in is valid this cycle
//   clr_stats  : synchronous clear of err_count / wrap_count (wins over increments)
//   locked     : checker is in LOCKED state
//   err_pulse  : one-cycle pulse on a sequence error while locked
//   expected   : next expected sample value
//   err_count  : saturating error count
//   wrap_count : saturating count of matched wrap samples while locked
module count_seq_checker #(
    parameter int WIDTH    = 4,
    parameter int DIR      = 0,
    parameter int LOCK_CNT = 2,
    parameter int STAT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  cnt_in,
    input  logic              cnt_valid,
    input  logic              clr_stats,
    output logic              locked,
    output logic              err_pulse,
    output logic [WIDTH-1:0]  expected,
    output logic [STAT_W-1:0] err_count,
    output logic [STAT_W-1:0] wrap_count
);

    typedef enum logic {
        ACQ    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // LOCK_CNT is limited to 15, so a 4-bit run length is always enough.
    localparam logic [3:0]        LOCK_VAL = 4'(LOCK_CNT);
    localparam logic [WIDTH-1:0]  ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0]  WRAP_TGT = (DIR != 0) ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    state_t            state_reg, state_next;
    logic [3:0]        run_len_reg, run_len_next;
    logic [WIDTH-1:0]  expected_reg, expected_next;
    logic              err_pulse_reg, err_pulse_next;
    logic [STAT_W-1:0] err_count_reg, err_count_next;
    logic [STAT_W-1:0] wrap_count_reg, wrap_count_next;
    logic              err_inc, wrap_inc;
    logic [WIDTH-1:0]  cnt_succ;
    logic [3:0]        run_inc;

    // Successor of the current sample. Unsigned arithmetic wraps naturally.
    assign cnt_succ = (DIR != 0) ? (cnt_in + ONE) : (cnt_in - ONE);
    assign run_inc  = run_len_reg + 4'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ACQ;
            run_len_reg    <= 4'd0;
            expected_reg   <= {WIDTH{1'b0}};
            err_pulse_reg  <= 1'b0;
            err_count_reg  <= {STAT_W{1'b0}};
            wrap_count_reg <= {STAT_W{1'b0}};
        end else begin
            state_reg      <= state_next;
            run_len_reg    <= run_len_next;
            expected_reg   <= expected_next;
            err_pulse_reg  <= err_pulse_next;
            err_count_reg  <= err_count_next;
            wrap_count_reg <= wrap_count_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        run_len_next   = run_len_reg;
        expected_next  = expected_reg;
        err_pulse_next = 1'b0;
        err_inc        = 1'b0;
        wrap_inc       = 1'b0;

        if (cnt_valid) begin
            // Every valid sample becomes the reference for the next one,
            // whether it matched or not.
            expected_next = cnt_succ;
            unique case (state_reg)
                ACQ: begin
                    if (run_len_reg == 4'd0) begin
                        run_len_next = 4'd1;
                    end else if (cnt_in == expected_reg) begin
                        run_len_next = run_inc;
                        if (run_inc == LOCK_VAL) begin
                            state_next = LOCKED;
                        end
                    end else begin
                        // Mismatch while acquiring only restarts the run;
                        // it is not an error.
                        run_len_next = 4'd1;
                    end
                end
                LOCKED: begin
                    if (cnt_in == expected_reg) begin
                        wrap_inc = (cnt_in == WRAP_TGT);
                    end else begin
                        err_pulse_next = 1'b1;
                        err_inc        = 1'b1;
                        state_next     = ACQ;
                        run_len_next   = 4'd1;
                    end
                end
                default: state_next = ACQ;
            endcase
        end
    end

    // Statistic counters. A clear takes priority over a coincident increment.
    always_comb begin
        err_count_next  = err_count_reg;
        wrap_count_next = wrap_count_reg;
        if (clr_stats) begin
            err_count_next  = {STAT_W{1'b0}};
            wrap_count_next = {STAT_W{1'b0}};
        end else begin
            if (err_inc && (err_count_reg != STAT_MAX)) begin
                err_count_next = err_count_reg + STAT_W'(1);
            end
            if (wrap_inc && (wrap_count_reg != STAT_MAX)) begin
                wrap_count_next = wrap_count_reg + STAT_W'(1);
            end
        end
    end

    assign locked     = (state_reg == LOCKED);
    assign err_pulse  = err_pulse_reg;
    assign expected   = expected_reg;
    assign err_count  = err_count_reg;
    assign wrap_count = wrap_count_reg;

endmodule

// File: tb/tb_count_seq_checker.sv
// Testbench for count_seq_checker.
//
// Two instances share clock, reset, valid and clr_stats:
//   dut_a : DIR=0, LOCK_CNT=2, STAT_W=2 (scripted stimulus)
//   dut_b : DIR=1, LOCK_CNT=3, STAT_W=8 (up-counting stream with periodic faults)
//
// A behavioural model predicts every output. The prediction is queued when
// the stimulus is driven and compared one time step after the next rising
// edge.
module tb_count_seq_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cnt_valid = 1'b0;
    logic       clr_stats = 1'b0;
    logic [3:0] cnt_a = 4'd0;
    logic [3:0] cnt_b = 4'd0;

    logic       locked_a, err_a;
    logic [3:0] exp_a;
    logic [1:0] errc_a, wrapc_a;
    logic       locked_b, err_b;
    logic [3:0] exp_b;
    logic [7:0] errc_b, wrapc_b;

    always #5 clk = ~clk;

    count_seq_checker #(.WIDTH(4), .DIR(0), .LOCK_CNT(2), .STAT_W(2)) dut_a (
        .clk(clk), .reset(reset), .cnt_in(cnt_a), .cnt_valid(cnt_valid),
        .clr_stats(clr_stats), .locked(locked_a), .err_pulse(err_a),
        .expected(exp_a), .err_count(errc_a), .wrap_count(wrapc_a)
    );

    count_seq_checker #(.WIDTH(4), .DIR(1), .LOCK_CNT(3), .STAT_W(8)) dut_b (
        .clk(clk), .reset(reset), .cnt_in(cnt_b), .cnt_valid(cnt_valid),
        .clr_stats(clr_stats), .locked(locked_b), .err_pulse(err_b),
        .expected(exp_b), .err_count(errc_b), .wrap_count(wrapc_b)
    );

    typedef struct {
        int lk;
        int ep;
        int ex;
        int ec;
        int wc;
    } pred_t;

    typedef struct {
        pred_t a;
        pred_t b;
    } sb_t;

    sb_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Model parameters and state, one entry per instance.
    int m_dir[2]  = '{0, 1};
    int m_lc[2]   = '{2, 3};
    int m_smax[2] = '{3, 255};
    int m_lock[2], m_run[2], m_exp[2], m_errp[2], m_errc[2], m_wrapc[2];

    int b_next  = 0;
    int b_steps = 0;

    task automatic chk(input string tag, input int obs, input int want);
        n_checks++;
        if (obs != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d at %0t", tag, obs, want, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_lock[i]  = 0;
            m_run[i]   = 0;
            m_exp[i]   = 0;
            m_errp[i]  = 0;
            m_errc[i]  = 0;
            m_wrapc[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input bit v, input int s, input bit clr);
        bit ei = 0;
        bit wi = 0;
        m_errp[i] = 0;
        if (v) begin
            if (m_lock[i] == 0) begin
                if (m_run[i] == 0) begin
                    m_run[i] = 1;
                end else if (s == m_exp[i]) begin
                    m_run[i]++;
                    if (m_run[i] == m_lc[i]) m_lock[i] = 1;
                end else begin
                    m_run[i] = 1;
                end
            end else if (s == m_exp[i]) begin
                if (s == ((m_dir[i] != 0) ? 0 : 15)) wi = 1;
            end else begin
                m_errp[i] = 1;
                ei        = 1;
                m_lock[i] = 0;
                m_run[i]  = 1;
            end
            m_exp[i] = (m_dir[i] != 0) ? (s + 1) % 16 : (s + 15) % 16;
        end
        if (clr) begin
            m_errc[i]  = 0;
            m_wrapc[i] = 0;
        end else begin
            if (ei && m_errc[i] < m_smax[i]) m_errc[i]++;
            if (wi && m_wrapc[i] < m_smax[i]) m_wrapc[i]++;
        end
    endtask

    function automatic pred_t snap(input int i);
        pred_t p;
        p.lk = m_lock[i];
        p.ep = m_errp[i];
        p.ex = m_exp[i];
        p.ec = m_errc[i];
        p.wc = m_wrapc[i];
        return p;
    endfunction

    // One clock of stimulus. Called at a falling edge; returns at the next one.
    task automatic cycle(input bit v, input int a, input bit clr);
        int sb;
        sb_t e;
        sb_t got;
        sb = b_next;
        if (v) begin
            b_steps++;
            if (b_steps % 17 == 0) sb = (b_next + 7) % 16;
            b_next = (sb + 1) % 16;
        end
        cnt_valid = v;
        cnt_a     = 4'(a);
        cnt_b     = 4'(sb);
        clr_stats = clr;
        model_step(0, v, a, clr);
        model_step(1, v, sb, clr);
        e.a = snap(0);
        e.b = snap(1);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        $display("t=%0t v=%0d a=%0d b=%0d clr=%0d | A lk=%0d ep=%0d ex=%0d ec=%0d wc=%0d | B lk=%0d ep=%0d ex=%0d ec=%0d wc=%0d",
                 $time, v, a, sb, clr, locked_a, err_a, exp_a, errc_a, wrapc_a,
                 locked_b, err_b, exp_b, errc_b, wrapc_b);
        chk("a_locked", int'(locked_a), got.a.lk);
        chk("a_err_pulse", int'(err_a), got.a.ep);
        chk("a_expected", int'(exp_a), got.a.ex);
        chk("a_err_count", int'(errc_a), got.a.ec);
        chk("a_wrap_count", int'(wrapc_a), got.a.wc);
        chk("b_locked", int'(locked_b), got.b.lk);
        chk("b_err_pulse", int'(err_b), got.b.ep);
        chk("b_expected", int'(exp_b), got.b.ex);
        chk("b_err_count", int'(errc_b), got.b.ec);
        chk("b_wrap_count", int'(wrapc_b), got.b.wc);
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Idle after reset: everything at reset values.
        cycle(0, 0, 0);
        chk("rst_expected", int'(exp_a), 0);

        // Acquire: 15, 14, 13 -> locked after 14, expected 12 after 13.
        cycle(1, 15, 0);
        cycle(1, 14, 0);
        chk("lock_after_2", int'(locked_a), 1);
        cycle(1, 13, 0);
        chk("exp_after_3", int'(exp_a), 12);

        // Run down through 0 and wrap to 15, 14.
        for (int v = 12; v >= 0; v--) cycle(1, v, 0);
        cycle(1, 15, 0);
        chk("wrap_once", int'(wrapc_a), 1);
        cycle(1, 14, 0);

        // Reach expected 9, inject 5, then relock on 4.
        for (int v = 13; v >= 10; v--) cycle(1, v, 0);
        cycle(1, 5, 0);
        chk("err_expected", int'(exp_a), 4);
        cycle(1, 4, 0);
        chk("relock", int'(locked_a), 1);

        // Gaps in valid with in-sequence values.
        cycle(1, 3, 0);
        cycle(0, 9, 0);
        cycle(0, 9, 0);
        cycle(1, 2, 0);

        // Four more errors, each followed by a relock sample: err_count saturates.
        for (int k = 0; k < 4; k++) begin
            cycle(1, (m_exp[0] + 11) % 16, 0);
            cycle(1, m_exp[0], 0);
        end
        chk("err_sat", int'(errc_a), 3);

        // Step down to the wrap target, then clear on the wrap-match cycle.
        for (int n = 0; n < 20 && m_exp[0] != 15; n++) cycle(1, m_exp[0], 0);
        cycle(1, 15, 1);
        chk("clr_wrap", int'(wrapc_a), 0);
        cycle(1, 14, 0);
        cycle(1, 13, 0);

        // Reset asserted mid-stream: lock drops without a clock edge.
        reset = 1'b0;
        #1;
        chk("midrst_locked", int'(locked_a), 0);
        chk("midrst_errc", int'(errc_a), 0);
        chk("midrst_wrapc", int'(wrapc_a), 0);
        chk("midrst_locked_b", int'(locked_b), 0);
        model_reset();
        b_next = 0;
        @(negedge clk);
        reset = 1'b1;
        cycle(0, 0, 0);
        cycle(1, 7, 0);
        cycle(1, 6, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
